// File: rtl/burst_load_pkg.sv
// burst_load_pkg
//   Shared definitions for the burst load engine: FSM state encoding,
//   burst-code and byte-code decode helpers, and the default SMC address
//   interleave step.
package burst_load_pkg;

    localparam int LDB_INTLV_STEP = 64;
    localparam int LDB_BYTE_CNT   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_AR_REQ  = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } ldb_state_t;

    // Burst code to AXI len (beats - 1): 00=1, 01=2, 10=4, 11=8 beats.
    function automatic logic [7:0] brst_to_len(input logic [1:0] brst);
        logic [7:0] len;
        case (brst)
            2'b00:   len = 8'd0;
            2'b01:   len = 8'd1;
            2'b10:   len = 8'd3;
            default: len = 8'd7;
        endcase
        return len;
    endfunction

    // Byte code to byte-enable mask: 0 enables every byte, n enables the low n bytes.
    function automatic logic [LDB_BYTE_CNT-1:0] byte_code_to_mask(input logic [3:0] code);
        logic [LDB_BYTE_CNT-1:0] mask;
        mask = '0;
        for (int i = 0; i < LDB_BYTE_CNT; i++) begin
            mask[i] = (code == 4'd0) || (i < int'(code));
        end
        return mask;
    endfunction

endpackage

// File: rtl/ldb_smc_scan.sv
// ldb_smc_scan
//   Combinational priority finder: returns the lowest enabled SMC whose
//   index is at or above start_idx.
// Ports:
//   strb       in   SMC enable bits
//   start_idx  in   first index eligible for selection
//   found      out  an eligible SMC exists
//   idx        out  index of that SMC (0 when none is found)
module ldb_smc_scan #(
    parameter int SMC_COUNT = 6,
    parameter int IDX_W     = 3
) (
    input  logic [SMC_COUNT-1:0] strb,
    input  logic [IDX_W-1:0]     start_idx,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    // Walk from the top down so the lowest eligible index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = SMC_COUNT - 1; i >= 0; i--) begin
            if (strb[i] && (IDX_W'(i) >= start_idx)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/burst_load.sv
// burst_load
//   Burst Load engine. Accepts an LDB command, issues one read burst per
//   enabled SMC to axi_ldb, and writes the returned beats into the target
//   UR with the command's byte mask.
//   Optional feature macro: BURST_LOAD_TIMEOUT_EN adds an 8-bit stall
//   counter that abandons a stuck request or burst after TIMEOUT_CYCLES.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ldb_u_*                  command in (valid/ready + fields)
//   ldb_d_*                  completion out, held until ldb_d_ready
//   state                    debug state
//   ldb2ldb_valid/ready/addr/burst_len   read-burst request to axi_ldb
//   ldb2ldb_rvalid/rdata/rlast           read beats (never backpressured)
//   ur_we/wid/waddr/wdata/wstrb          UR write port
//
// state   | meaning
// IDLE    | ready for a command
// SCAN    | pick next enabled SMC, or finish
// AR_REQ  | read request held until accepted
// RD_DATA | write returned beats into the UR
// DONE    | completion held until acknowledged
module burst_load
    import burst_load_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int SMC_COUNT      = 6,
    parameter int UR_BYTE_CNT    = 16,
    parameter int INTLV_STEP     = LDB_INTLV_STEP,
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ldb_u_valid,
    output logic                   ldb_u_ready,
    input  logic [SMC_COUNT-1:0]   ldb_u_smc_strb,
    input  logic [3:0]             ldb_u_byte_strb,
    input  logic [1:0]             ldb_u_brst,
    input  logic [ADDR_WIDTH-1:0]  ldb_u_gr_base_addr,
    input  logic [3:0]             ldb_u_ur_id,
    input  logic [10:0]            ldb_u_ur_addr,
    output logic                   ldb_d_valid,
    output logic                   ldb_d_done,
    output logic                   ldb_d_err,
    input  logic                   ldb_d_ready,
    output logic [2:0]             state,
    output logic                   ldb2ldb_valid,
    input  logic                   ldb2ldb_ready,
    output logic [ADDR_WIDTH-1:0]  ldb2ldb_addr,
    output logic [7:0]             ldb2ldb_burst_len,
    input  logic                   ldb2ldb_rvalid,
    input  logic [DATA_WIDTH-1:0]  ldb2ldb_rdata,
    input  logic                   ldb2ldb_rlast,
    output logic                   ur_we,
    output logic [3:0]             ur_wid,
    output logic [10:0]            ur_waddr,
    output logic [DATA_WIDTH-1:0]  ur_wdata,
    output logic [UR_BYTE_CNT-1:0] ur_wstrb
);

    // Index must be able to hold SMC_COUNT (one past the last SMC).
    localparam int IDX_W = $clog2(SMC_COUNT + 1);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit stall counter");
    end

    ldb_state_t state_q, state_d;

    logic [SMC_COUNT-1:0]   cmd_strb;
    logic [UR_BYTE_CNT-1:0] cmd_mask;
    logic [7:0]             cmd_len;
    logic [ADDR_WIDTH-1:0]  cmd_base;
    logic [3:0]             cmd_ur_id;
    logic [10:0]            ur_ptr;
    logic [IDX_W-1:0]       smc_idx;
    logic [IDX_W-1:0]       cur_idx;
    logic [8:0]             beat_cnt;
    logic                   err_flag;

    logic                   scan_found;
    logic [IDX_W-1:0]       scan_idx;
    logic                   in_rd;
    logic                   beat_ok;
    logic                   last_beat;
    logic [8:0]             beats_seen;
    logic                   count_bad;
    logic                   timeout_hit;

    ldb_smc_scan #(
        .SMC_COUNT (SMC_COUNT),
        .IDX_W     (IDX_W)
    ) u_scan (
        .strb      (cmd_strb),
        .start_idx (smc_idx),
        .found     (scan_found),
        .idx       (scan_idx)
    );

    assign in_rd      = (state_q == ST_RD_DATA);
    // beat_cnt counts accepted beats; a beat is accepted while fewer than len+1 have landed.
    assign beat_ok    = in_rd && ldb2ldb_rvalid && (beat_cnt <= {1'b0, cmd_len});
    assign last_beat  = in_rd && ldb2ldb_rvalid && ldb2ldb_rlast;
    assign beats_seen = beat_cnt + {8'd0, beat_ok};
    assign count_bad  = (beats_seen != ({1'b0, cmd_len} + 9'd1));

`ifdef BURST_LOAD_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       stall_busy;
    logic       stall_event;

    assign stall_busy  = (state_q == ST_AR_REQ) || in_rd;
    assign stall_event = ((state_q == ST_AR_REQ) && ldb2ldb_ready) || (in_rd && ldb2ldb_rvalid);
    assign timeout_hit = stall_busy && !stall_event && (stall_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_busy && !stall_event && !timeout_hit) begin
            stall_cnt <= stall_cnt + 8'd1;
        end else begin
            stall_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (ldb_u_valid) state_d = ST_SCAN;
            ST_SCAN:    state_d = scan_found ? ST_AR_REQ : ST_DONE;
            ST_AR_REQ: begin
                if (ldb2ldb_ready) begin
                    state_d = ST_RD_DATA;
                end else if (timeout_hit) begin
                    state_d = ST_SCAN;
                end
            end
            ST_RD_DATA: if (last_beat || timeout_hit) state_d = ST_SCAN;
            ST_DONE:    if (ldb_d_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_strb          <= '0;
            cmd_mask          <= '0;
            cmd_len           <= '0;
            cmd_base          <= '0;
            cmd_ur_id         <= '0;
            ur_ptr            <= '0;
            smc_idx           <= '0;
            cur_idx           <= '0;
            beat_cnt          <= '0;
            err_flag          <= 1'b0;
            ldb2ldb_addr      <= '0;
            ldb2ldb_burst_len <= '0;
            ur_we             <= 1'b0;
            ur_wid            <= '0;
            ur_waddr          <= '0;
            ur_wdata          <= '0;
            ur_wstrb          <= '0;
        end else begin
            ur_we <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ldb_u_valid) begin
                        cmd_strb  <= ldb_u_smc_strb;
                        cmd_mask  <= UR_BYTE_CNT'(byte_code_to_mask(ldb_u_byte_strb));
                        cmd_len   <= brst_to_len(ldb_u_brst);
                        cmd_base  <= ldb_u_gr_base_addr;
                        cmd_ur_id <= ldb_u_ur_id;
                        ur_ptr    <= ldb_u_ur_addr;
                        smc_idx   <= '0;
                        err_flag  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (scan_found) begin
                        cur_idx           <= scan_idx;
                        ldb2ldb_addr      <= cmd_base
                                           + ADDR_WIDTH'(scan_idx) * ADDR_WIDTH'(INTLV_STEP);
                        ldb2ldb_burst_len <= cmd_len;
                    end
                end
                ST_AR_REQ: begin
                    if (ldb2ldb_ready) begin
                        beat_cnt <= '0;
                    end else if (timeout_hit) begin
                        err_flag <= 1'b1;
                        smc_idx  <= cur_idx + IDX_W'(1);
                    end
                end
                ST_RD_DATA: begin
                    if (beat_ok) begin
                        ur_we    <= 1'b1;
                        ur_wid   <= cmd_ur_id;
                        ur_waddr <= ur_ptr;
                        ur_wdata <= ldb2ldb_rdata;
                        ur_wstrb <= cmd_mask;
                        ur_ptr   <= ur_ptr + 11'd1;
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                    // Surplus beats are swallowed but poison the completion.
                    if (ldb2ldb_rvalid && !beat_ok) begin
                        err_flag <= 1'b1;
                    end
                    if ((last_beat && count_bad) || timeout_hit) begin
                        err_flag <= 1'b1;
                    end
                    if (last_beat || timeout_hit) begin
                        smc_idx <= cur_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ldb_u_ready   = (state_q == ST_IDLE);
    assign ldb2ldb_valid = (state_q == ST_AR_REQ);
    assign ldb_d_valid   = (state_q == ST_DONE);
    assign ldb_d_done    = (state_q == ST_DONE);
    assign ldb_d_err     = (state_q == ST_DONE) && err_flag;
    assign state         = state_q;

endmodule

// File: tb/tb_burst_load.sv
module tb_burst_load;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int NS = 6;
    localparam int BC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ldb_u_valid = 1'b0;
    logic          ldb_u_ready;
    logic [NS-1:0] ldb_u_smc_strb = '0;
    logic [3:0]    ldb_u_byte_strb = '0;
    logic [1:0]    ldb_u_brst = '0;
    logic [AW-1:0] ldb_u_gr_base_addr = '0;
    logic [3:0]    ldb_u_ur_id = '0;
    logic [10:0]   ldb_u_ur_addr = '0;
    logic          ldb_d_valid, ldb_d_done, ldb_d_err;
    logic          ldb_d_ready = 1'b0;
    logic [2:0]    state;
    logic          ldb2ldb_valid;
    logic          ldb2ldb_ready = 1'b0;
    logic [AW-1:0] ldb2ldb_addr;
    logic [7:0]    ldb2ldb_burst_len;
    logic          ldb2ldb_rvalid = 1'b0;
    logic [DW-1:0] ldb2ldb_rdata = '0;
    logic          ldb2ldb_rlast = 1'b0;
    logic          ur_we;
    logic [3:0]    ur_wid;
    logic [10:0]   ur_waddr;
    logic [DW-1:0] ur_wdata;
    logic [BC-1:0] ur_wstrb;

    always #5 clk = ~clk;

    burst_load dut (
        .clk(clk), .rst(rst),
        .ldb_u_valid(ldb_u_valid), .ldb_u_ready(ldb_u_ready),
        .ldb_u_smc_strb(ldb_u_smc_strb), .ldb_u_byte_strb(ldb_u_byte_strb),
        .ldb_u_brst(ldb_u_brst), .ldb_u_gr_base_addr(ldb_u_gr_base_addr),
        .ldb_u_ur_id(ldb_u_ur_id), .ldb_u_ur_addr(ldb_u_ur_addr),
        .ldb_d_valid(ldb_d_valid), .ldb_d_done(ldb_d_done), .ldb_d_err(ldb_d_err),
        .ldb_d_ready(ldb_d_ready), .state(state),
        .ldb2ldb_valid(ldb2ldb_valid), .ldb2ldb_ready(ldb2ldb_ready),
        .ldb2ldb_addr(ldb2ldb_addr), .ldb2ldb_burst_len(ldb2ldb_burst_len),
        .ldb2ldb_rvalid(ldb2ldb_rvalid), .ldb2ldb_rdata(ldb2ldb_rdata),
        .ldb2ldb_rlast(ldb2ldb_rlast),
        .ur_we(ur_we), .ur_wid(ur_wid), .ur_waddr(ur_waddr),
        .ur_wdata(ur_wdata), .ur_wstrb(ur_wstrb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observed UR writes.
    logic [10:0]   wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [BC-1:0] ws_q[$];
    logic [3:0]    wi_q[$];

    always @(negedge clk) begin
        if (ur_we === 1'b1) begin
            wa_q.push_back(ur_waddr);
            wd_q.push_back(ur_wdata);
            ws_q.push_back(ur_wstrb);
            wi_q.push_back(ur_wid);
        end
    end

    // Observations of one command run.
    logic [AW-1:0] req_addr_q[$];
    logic [7:0]    req_len_q[$];
    int            beats_q[$];
    logic [DW-1:0] sent_q[$];
    int            gap_q[$];
    int            stall_q[$];
    bit            we_obs_q[$];
    bit            we_exp_q[$];
    int            first_lat;
    int            done_k;
    bit            hung;
    bit            done_held;
    bit            idle_after;
    logic          err_seen;

    int fixed_beats = 0;
    bit rand_beats = 1'b0;
    bit no_ready = 1'b0;

    // Reference model outputs.
    logic [AW-1:0] e_addr_q[$];
    logic [10:0]   e_wa_q[$];
    logic [DW-1:0] e_wd_q[$];
    logic [BC-1:0] e_strb;
    logic [7:0]    e_len;
    logic          e_err;

    function automatic void model(input logic [NS-1:0] s, input logic [1:0] b,
                                  input logic [3:0] c, input logic [AW-1:0] ba,
                                  input logic [10:0] ua);
        int len, ptr, bi;
        e_addr_q.delete(); e_wa_q.delete(); e_wd_q.delete();
        len    = (1 << b) - 1;
        e_len  = 8'(len);
        e_strb = (c == 4'd0) ? {BC{1'b1}} : BC'((1 << c) - 1);
        for (int i = 0; i < NS; i++)
            if (s[i]) e_addr_q.push_back(ba + AW'(i * 64));
        ptr = int'(ua); bi = 0; e_err = 1'b0;
        foreach (beats_q[j]) begin
            if (beats_q[j] != len + 1) e_err = 1'b1;
            for (int k = 0; k < beats_q[j]; k++) begin
                if (k <= len) begin
                    e_wa_q.push_back(11'(ptr));
                    e_wd_q.push_back(sent_q[bi]);
                    ptr = (ptr + 1) % 2048;
                end
                bi++;
            end
        end
        if (no_ready) e_err = (s != '0);
    endfunction

    // Issue one command, act as axi_ldb, and acknowledge the completion.
    task automatic run_cmd(input logic [NS-1:0] s, input logic [1:0] b, input logic [3:0] c,
                           input logic [AW-1:0] ba, input logic [3:0] id, input logic [10:0] ua);
        int k, budget, len, nb, m, st;
        logic [DW-1:0] d;
        wa_q.delete(); wd_q.delete(); ws_q.delete(); wi_q.delete();
        req_addr_q.delete(); req_len_q.delete(); beats_q.delete(); sent_q.delete();
        gap_q.delete(); stall_q.delete(); we_obs_q.delete(); we_exp_q.delete();
        first_lat = -1; hung = 1'b0; done_held = 1'b1;
        len = (1 << b) - 1;
        @(negedge clk);
        ldb_u_smc_strb = s; ldb_u_brst = b; ldb_u_byte_strb = c;
        ldb_u_gr_base_addr = ba; ldb_u_ur_id = id; ldb_u_ur_addr = ua;
        ldb_u_valid = 1'b1;
        @(negedge clk);
        ldb_u_valid = 1'b0;
        k = 1; budget = 0;
        while (ldb_d_done !== 1'b1 && !hung) begin
            if (ldb2ldb_valid === 1'b1) begin
                if (first_lat < 0) first_lat = k;
                req_addr_q.push_back(ldb2ldb_addr);
                req_len_q.push_back(ldb2ldb_burst_len);
                if (no_ready) begin
                    st = 0;
                    while (ldb2ldb_valid === 1'b1 && st < 1000) begin @(negedge clk); st++; end
                    stall_q.push_back(st);
                end else begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    ldb2ldb_ready = 1'b1;
                    @(negedge clk);
                    ldb2ldb_ready = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    nb = (fixed_beats > 0) ? fixed_beats :
                         rand_beats ? int'($urandom_range(1, len + 2)) : len + 1;
                    beats_q.push_back(nb);
                    for (int i = 0; i < nb; i++) begin
                        d = {$urandom, $urandom, $urandom, $urandom};
                        sent_q.push_back(d);
                        ldb2ldb_rvalid = 1'b1; ldb2ldb_rdata = d; ldb2ldb_rlast = (i == nb - 1);
                        @(negedge clk);
                        ldb2ldb_rvalid = 1'b0; ldb2ldb_rlast = 1'b0;
                        we_exp_q.push_back(i <= len);
                        we_obs_q.push_back(ur_we === 1'b1);
                        if (i != nb - 1) repeat ($urandom_range(0, 1)) @(negedge clk);
                    end
                    m = 1;
                    while (ldb2ldb_valid !== 1'b1 && ldb_d_done !== 1'b1 && m < 20) begin
                        @(negedge clk); m++;
                    end
                    gap_q.push_back(m);
                end
                budget += 50;
            end else begin
                @(negedge clk); k++; budget++;
            end
            if (budget > 5000) hung = 1'b1;
        end
        done_k = k;
        err_seen = ldb_d_err;
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            if (ldb_d_done !== 1'b1 || ldb_d_valid !== 1'b1) done_held = 1'b0;
        end
        ldb_d_ready = 1'b1;
        @(negedge clk);
        ldb_d_ready = 1'b0;
        idle_after = (ldb_u_ready === 1'b1) && (ldb_d_done === 1'b0) && (state === 3'd0);
        model(s, b, c, ba, ua);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ldb_u_ready, state} !== 4'b1_000) begin
            n_bad++; $display("FAIL reset_ready_state: got %b want 1000", {ldb_u_ready, state});
        end
        n_cmp++;
        if ({ldb_d_valid, ldb_d_done, ldb_d_err, ldb2ldb_valid, ur_we} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000",
                              {ldb_d_valid, ldb_d_done, ldb_d_err, ldb2ldb_valid, ur_we});
        end
        n_cmp++;
        if ({ldb2ldb_addr, ldb2ldb_burst_len, ur_wid, ur_waddr, ur_wstrb, ur_wdata} !== '0) begin
            n_bad++; $display("FAIL reset_data: got %0h want 0",
                              {ldb2ldb_addr, ldb2ldb_burst_len, ur_wid, ur_waddr, ur_wstrb, ur_wdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [NS-1:0] s; logic [1:0] b; logic [3:0] c; logic [AW-1:0] ba; logic [10:0] ua;
        for (int t = 0; t < 6; t++) begin
            fixed_beats = 0;
            case (t)
                0: begin s = 6'b000001; b = 2'b00; c = 4'h0; ba = 32'h1000;     ua = 11'd5;    end
                1: begin s = 6'b100101; b = 2'b10; c = 4'h9; ba = 32'h0;        ua = 11'd300;  end
                2: begin s = 6'b000001; b = 2'b11; c = 4'h3; ba = 32'h2000;     ua = 11'd2046; end
                3: begin s = 6'b000000; b = 2'b01; c = 4'h0; ba = 32'h3000;     ua = 11'd7;    end
                4: begin s = 6'b000001; b = 2'b10; c = 4'h0; ba = 32'h4000;     ua = 11'd9;
                         fixed_beats = 2; end
                default: begin s = 6'b110000; b = 2'b01; c = 4'hF; ba = 32'hFFFF_FFC0; ua = 11'd0; end
            endcase
            run_cmd(s, b, c, ba, 4'(t + 3), ua);
            fixed_beats = 0;
            n_cmp++;
            if (hung) begin n_bad++; $display("FAIL dir%0d_hang: no completion within budget", t); end
            n_cmp++;
            if (req_addr_q.size() != e_addr_q.size()) begin
                n_bad++; $display("FAIL dir%0d_req_count: got %0d want %0d", t, req_addr_q.size(), e_addr_q.size());
            end else begin
                foreach (e_addr_q[i]) begin
                    n_cmp++;
                    if (req_addr_q[i] !== e_addr_q[i] || req_len_q[i] !== e_len) begin
                        n_bad++; $display("FAIL dir%0d_req%0d: got %0h/len %0d want %0h/len %0d",
                                          t, i, req_addr_q[i], req_len_q[i], e_addr_q[i], e_len);
                    end
                end
            end
            n_cmp++;
            if (e_addr_q.size() > 0 && first_lat != 2) begin
                n_bad++; $display("FAIL dir%0d_req_latency: got %0d want 2", t, first_lat);
            end else if (e_addr_q.size() == 0 && done_k != 2) begin
                n_bad++; $display("FAIL dir%0d_done_latency: got %0d want 2", t, done_k);
            end
            foreach (gap_q[i]) begin
                n_cmp++;
                if (gap_q[i] != 2) begin n_bad++; $display("FAIL dir%0d_rlast_gap%0d: got %0d want 2", t, i, gap_q[i]); end
            end
            foreach (we_exp_q[i]) begin
                n_cmp++;
                if (we_obs_q[i] != we_exp_q[i]) begin
                    n_bad++; $display("FAIL dir%0d_we_beat%0d: got %0d want %0d", t, i, we_obs_q[i], we_exp_q[i]);
                end
            end
            n_cmp++;
            if (wa_q.size() != e_wa_q.size()) begin
                n_bad++; $display("FAIL dir%0d_write_count: got %0d want %0d", t, wa_q.size(), e_wa_q.size());
            end else begin
                foreach (e_wa_q[i]) begin
                    n_cmp++;
                    if (wa_q[i] !== e_wa_q[i] || wd_q[i] !== e_wd_q[i] || ws_q[i] !== e_strb || wi_q[i] !== 4'(t + 3)) begin
                        n_bad++; $display("FAIL dir%0d_write%0d: got a=%0d s=%h id=%0d want a=%0d s=%h id=%0d",
                                          t, i, wa_q[i], ws_q[i], wi_q[i], e_wa_q[i], e_strb, t + 3);
                    end
                end
            end
            n_cmp++;
            if (err_seen !== e_err) begin n_bad++; $display("FAIL dir%0d_err: got %b want %b", t, err_seen, e_err); end
            n_cmp++;
            if (!done_held || !idle_after) begin
                n_bad++; $display("FAIL dir%0d_done_handshake: held %0d idle %0d want 1 1", t, done_held, idle_after);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NS-1:0] s; logic [1:0] b; logic [3:0] c; logic [AW-1:0] ba; logic [3:0] id; logic [10:0] ua;
        for (int t = 0; t < 16; t++) begin
            s = NS'($urandom); b = 2'($urandom); c = 4'($urandom);
            ba = $urandom; id = 4'($urandom); ua = 11'($urandom);
            rand_beats = t[0];
            run_cmd(s, b, c, ba, id, ua);
            rand_beats = 1'b0;
            n_cmp++;
            if (hung || req_addr_q.size() != e_addr_q.size()) begin
                n_bad++; $display("FAIL rnd%0d_requests: got %0d hung %0d want %0d", t, req_addr_q.size(), hung, e_addr_q.size());
            end else begin
                foreach (e_addr_q[i]) begin
                    n_cmp++;
                    if (req_addr_q[i] !== e_addr_q[i] || req_len_q[i] !== e_len) begin
                        n_bad++; $display("FAIL rnd%0d_req%0d: got %0h want %0h", t, i, req_addr_q[i], e_addr_q[i]);
                    end
                end
            end
            n_cmp++;
            if (wa_q.size() != e_wa_q.size()) begin
                n_bad++; $display("FAIL rnd%0d_write_count: got %0d want %0d", t, wa_q.size(), e_wa_q.size());
            end else begin
                foreach (e_wa_q[i]) begin
                    n_cmp++;
                    if (wa_q[i] !== e_wa_q[i] || wd_q[i] !== e_wd_q[i] || ws_q[i] !== e_strb || wi_q[i] !== id) begin
                        n_bad++; $display("FAIL rnd%0d_write%0d: got a=%0d d=%h want a=%0d d=%h", t, i, wa_q[i], wd_q[i], e_wa_q[i], e_wd_q[i]);
                    end
                end
            end
            foreach (gap_q[i]) begin
                n_cmp++;
                if (gap_q[i] != 2) begin n_bad++; $display("FAIL rnd%0d_rlast_gap%0d: got %0d want 2", t, i, gap_q[i]); end
            end
            n_cmp++;
            if (err_seen !== e_err || !idle_after) begin
                n_bad++; $display("FAIL rnd%0d_completion: got err %b idle %0d want err %b idle 1", t, err_seen, idle_after, e_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk);
        ldb_u_smc_strb = 6'b000001; ldb_u_brst = 2'b11; ldb_u_byte_strb = 4'h0;
        ldb_u_gr_base_addr = 32'h5000; ldb_u_ur_addr = 11'd100; ldb_u_valid = 1'b1;
        @(negedge clk);
        ldb_u_valid = 1'b0;
        w = 0;
        while (ldb2ldb_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        n_cmp++;
        if (ldb2ldb_valid !== 1'b1) begin n_bad++; $display("FAIL mid_request: got valid %b want 1", ldb2ldb_valid); end
        // A beat alongside the request handshake must be ignored.
        ldb2ldb_ready = 1'b1; ldb2ldb_rvalid = 1'b1; ldb2ldb_rdata = {4{32'hDEAD_BEEF}};
        @(negedge clk);
        ldb2ldb_ready = 1'b0; ldb2ldb_rvalid = 1'b0;
        n_cmp++;
        if (ur_we !== 1'b0) begin n_bad++; $display("FAIL ar_req_beat_ignored: got ur_we %b want 0", ur_we); end
        for (int i = 0; i < 3; i++) begin
            ldb2ldb_rvalid = 1'b1; ldb2ldb_rdata = {4{$urandom}};
            @(negedge clk);
        end
        ldb_u_valid = 1'b1;
        n_cmp++;
        if ({ldb_u_ready, state, ur_we} !== 5'b0_011_1) begin
            n_bad++; $display("FAIL mid_busy: got ready/state/we %b want 0_011_1", {ldb_u_ready, state, ur_we});
        end
        rst = 1'b1;
        @(negedge clk);
        ldb_u_valid = 1'b0; ldb2ldb_rvalid = 1'b0;
        n_cmp++;
        if ({ldb_u_ready, state, ur_we, ldb2ldb_valid, ldb_d_done, ldb_d_err} !== 8'b1_000_0000) begin
            n_bad++; $display("FAIL mid_reset_ctrl: got %b want 10000000",
                              {ldb_u_ready, state, ur_we, ldb2ldb_valid, ldb_d_done, ldb_d_err});
        end
        n_cmp++;
        if ({ur_waddr, ur_wdata, ldb2ldb_addr} !== '0) begin
            n_bad++; $display("FAIL mid_reset_data: got waddr %0d addr %0h want 0", ur_waddr, ldb2ldb_addr);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ldb_u_ready !== 1'b1 || state !== 3'd0) begin
            n_bad++; $display("FAIL mid_reset_stays_idle: got ready %b state %0d want 1 0", ldb_u_ready, state);
        end
    endtask

`ifdef BURST_LOAD_TIMEOUT_EN
    task automatic test_timeout();
        no_ready = 1'b1;
        run_cmd(6'b000011, 2'b01, 4'h0, 32'h8000, 4'd1, 11'd0);
        no_ready = 1'b0;
        n_cmp++;
        if (hung || stall_q.size() != 2) begin
            n_bad++; $display("FAIL timeout_requests: got %0d hung %0d want 2", stall_q.size(), hung);
        end else begin
            foreach (stall_q[i]) begin
                n_cmp++;
                if (stall_q[i] != 127) begin n_bad++; $display("FAIL timeout_stall%0d: got %0d want 127", i, stall_q[i]); end
            end
        end
        n_cmp++;
        if (err_seen !== 1'b1 || wa_q.size() != 0) begin
            n_bad++; $display("FAIL timeout_completion: got err %b writes %0d want 1 0", err_seen, wa_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
`ifdef BURST_LOAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/burst_load.md
# burst_load

Burst Load (LDB) engine: the read-direction counterpart of the burst store path. It accepts an LDB command, issues one read burst per enabled SMC to the AXI read agent (`axi_ldb`), and writes the returned beats into the target UR with the command's byte mask. It sits between the CRU command interface and `axi_ldb` on one side, and `ur_model` on the other.

## Interface
- `ADDR_WIDTH`, 32, external address width
- `DATA_WIDTH`, 128, beat / UR word width
- `SMC_COUNT`, 6, number of SMCs
- `UR_BYTE_CNT`, 16, byte-enable width (`DATA_WIDTH/8`)
- `INTLV_STEP`, 64, SMC address interleave in bytes
- `TIMEOUT_CYCLES`, 127, stall limit (used only with `BURST_LOAD_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ldb_u_valid`  in  1  command valid.
- `ldb_u_ready`  out  1  command accepted; high only in IDLE.
- `ldb_u_smc_strb`  in  SMC_COUNT  SMC enable, one bit per SMC.
- `ldb_u_byte_strb`  in  4  byte-mask code.
- `ldb_u_brst`  in  2  burst code: 00=1, 01=2, 10=4, 11=8 beats.
- `ldb_u_gr_base_addr`  in  ADDR_WIDTH  external base address.
- `ldb_u_ur_id`  in  4  target UR.
- `ldb_u_ur_addr`  in  11  UR start word address.
- `ldb_d_valid`, `ldb_d_done`  out  1  completion; held until acknowledged.
- `ldb_d_err`  out  1  completion carries an error; valid with `ldb_d_done`.
- `ldb_d_ready`  in  1  upper-layer acknowledge.
- `state`  out  3  debug state.
- `ldb2ldb_valid`  out  1  read-burst request valid.
- `ldb2ldb_ready`  in  1  `axi_ldb` accepts the request.
- `ldb2ldb_addr`  out  ADDR_WIDTH  burst address.
- `ldb2ldb_burst_len`  out  8  AXI len (0/1/3/7).
- `ldb2ldb_rvalid`  in  1  read beat valid. There is no backpressure: the block always accepts beats.
- `ldb2ldb_rdata`  in  DATA_WIDTH  read beat data.
- `ldb2ldb_rlast`  in  1  last beat of the burst.
- `ur_we`  out  1  UR write enable.
- `ur_wid`  out  4  UR id.
- `ur_waddr`  out  11  UR word address.
- `ur_wdata`  out  DATA_WIDTH  write data.
- `ur_wstrb`  out  UR_BYTE_CNT  byte enables.

## Operation
States: IDLE=0, SCAN=1, AR_REQ=2, RD_DATA=3, DONE=4.

- **IDLE**
  - On `ldb_u_valid`, latch all command fields.
  - Set `smc_idx=0`, `ur_ptr=ldb_u_ur_addr`, clear the error flag, then go to SCAN.
- **SCAN**
  - Find the lowest enabled SMC with index ≥ `smc_idx`, in one cycle.
  - If one is found, drive `ldb2ldb_addr = base + idx*INTLV_STEP` (modulo 2^ADDR_WIDTH) and `ldb2ldb_burst_len` from the burst code. Assert `ldb2ldb_valid` and go to AR_REQ.
  - If none is found, go to DONE. This includes `smc_strb=0`, which gives no request and no UR write.
- **AR_REQ**
  - Hold `ldb2ldb_valid` and its fields stable until `ldb2ldb_ready`.
  - Then deassert valid, clear the beat counter, and go to RD_DATA.
- **RD_DATA**
  - Each `rvalid` beat with counter ≤ `burst_len`:
    - write `ur_wdata=rdata`, `ur_waddr=ur_ptr`, `ur_wstrb=mask`;
    - increment `ur_ptr`, wrapping 2047→0;
    - increment the counter.
  - Beats beyond `burst_len+1` are dropped with no UR write, and the error flag is set.
  - On `rlast`:
    - if the beat count ≠ `burst_len+1`, set the error flag;
    - set `smc_idx = idx+1` and go to SCAN.
- **DONE**
  - Hold `ldb_d_valid=ldb_d_done=1` and `ldb_d_err`.
  - On `ldb_d_ready`, clear them and go to IDLE. `ldb_d_ready` sampled outside DONE is ignored.

Byte-mask code (applies to every beat):
- 0: all 16 bytes.
- n (1–15): the low n bytes.

## Timing
- Reset (synchronous, takes priority in every state):
  - state=IDLE;
  - all outputs 0, except `ldb_u_ready`, which is 1 in IDLE;
  - an in-flight command is abandoned without completion.
- Command accept to `ldb2ldb_valid`: 2 cycles (IDLE→SCAN→AR_REQ registered).
- `rvalid` to `ur_we`: 1 cycle (registered). `ur_we` is a single-cycle pulse per accepted beat, so back-to-back beats give back-to-back writes.
- Last `rlast` to `ldb_d_done`:
  - 2 cycles when no further SMC is enabled (RD_DATA→SCAN→DONE);
  - the next request starts 2 cycles after `rlast`.
- `rvalid` together with `ldb2ldb_ready` in AR_REQ is not legal from `axi_ldb`. If it occurs, the beat is ignored.
- A new `ldb_u_valid` while busy is not accepted (`ldb_u_ready=0`).

## Configuration
`BURST_LOAD_TIMEOUT_EN`:
- **Defined:**
  - An 8-bit stall counter runs in AR_REQ and RD_DATA and clears on each handshake or beat.
  - When it reaches `TIMEOUT_CYCLES`, deassert `ldb2ldb_valid`, set the error flag, and advance to the next SMC via SCAN.
- **Undefined:**
  - No counter; the block waits indefinitely.
  - `ldb_d_err` reflects only beat-count errors.

## Structure
- Package `burst_load_pkg` holds:
  - the state encoding;
  - the brst→len decode function;
  - the byte-code→mask function;
  - the `INTLV_STEP` default.
- One sub-module, `ldb_smc_scan`: a combinational priority finder (strobe + start index → found + index).

## Test plan
- smc_strb=6'b000001, brst=00, byte=0, base=0x1000, ur_addr=5 → one request (0x1000, len 0); one write at UR addr 5 with wstrb=16'hFFFF; done, err=0.
- smc_strb=6'b100101, brst=10, base=0x0 → requests to 0x000, 0x080, 0x140, each len 3; 12 UR writes to consecutive addresses.
- ur_addr=2046, brst=11, byte=4'h3 → writes at 2046, 2047, 0…5, each with wstrb=16'h0007.
- smc_strb=0 → no `ldb2ldb_valid`; `ldb_d_done` 2 cycles after accept; held until `ldb_d_ready`.
- brst=10 with `rlast` on beat 2 → 2 writes, `ldb_d_err=1`; `rst` asserted mid-RD_DATA → next cycle IDLE, all outputs 0.
- With `BURST_LOAD_TIMEOUT_EN`, `ldb2ldb_ready` never asserted → after 127 cycles the next SMC is requested or the command completes; `ldb_d_err=1`.
